// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM balance arbiter: FSM encoding, transaction
// types and default datapath widths.
package cajero_pkg;

  localparam int W_MONTO_DEF = 32;
  localparam int W_BAL_DEF   = 64;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic DEPOSITO = 1'b0;
  localparam logic RETIRO   = 1'b1;

  typedef struct packed {
    logic ok;
    logic fondos_insuf;
  } resultado_t;

endpackage

// File: rtl/arbitro_balance_rr_selector.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_TERM.
module rr_selector #(
  parameter int N_TERM = 4,
  parameter int W_IDX  = $clog2(N_TERM)
) (
  input  logic [N_TERM-1:0] i_req,
  input  logic [W_IDX-1:0]  i_ptr,
  output logic [W_IDX-1:0]  o_sel,
  output logic              o_valid
);

  logic [W_IDX:0] w_idx;

  // Scan from farthest to nearest so the nearest set bit wins the last write.
  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = N_TERM - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_ptr} + (W_IDX + 1)'(k);
      if (w_idx >= (W_IDX + 1)'(N_TERM)) begin
        w_idx = w_idx - (W_IDX + 1)'(N_TERM);
      end
      if (i_req[w_idx[W_IDX-1:0]]) begin
        o_sel   = w_idx[W_IDX-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_balance.sv
// Round-robin arbiter sharing one account balance and its add/subtract
// datapath between N_TERM terminals; IDLE -> EXEC -> RESP per transaction.
module arbitro_balance
  import cajero_pkg::*;
#(
  parameter int N_TERM  = 4,
  parameter int W_MONTO = W_MONTO_DEF,
  parameter int W_BAL   = W_BAL_DEF
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        Carga,
  input  logic [W_BAL-1:0]            Carga_valor,
  input  logic [N_TERM-1:0]           Req,
  input  logic [N_TERM-1:0]           Tipo_trans,
  input  logic [N_TERM*W_MONTO-1:0]   Monto,
  output logic [N_TERM-1:0]           Gnt,
  output logic [N_TERM-1:0]           Done,
  output logic                        Ok,
  output logic                        Fondos_insuficientes,
  output logic [W_BAL-1:0]            Balance,
  output logic                        Ocupado,
  output logic [1:0]                  o_estado
);

  // Handshake: Req is a level held by the terminal until its Done pulse; the
  // request is captured once in IDLE, Gnt marks the EXEC cycle and Done the
  // RESP cycle, and Ok/Fondos_insuficientes are meaningful only with Done.

  localparam int W_IDX = $clog2(N_TERM);

  logic [1:0]          r_state;
  logic [W_IDX-1:0]    r_ptr;
  logic [W_IDX-1:0]    r_sel;
  logic                r_tipo;
  logic [W_MONTO-1:0]  r_monto;
  logic [W_BAL-1:0]    r_balance;
  logic [N_TERM-1:0]   r_gnt;
  logic [N_TERM-1:0]   r_done;
  logic                r_ok;
  logic                r_fi;

  logic [W_IDX-1:0]    w_pick;
  logic                w_pick_valid;
  logic [W_IDX-1:0]    w_ptr_next;
  logic [W_BAL-1:0]    w_monto_ext;
  logic [W_BAL:0]      w_suma;
  logic [W_BAL-1:0]    w_nuevo;
  resultado_t          w_res;

  rr_selector #(
    .N_TERM (N_TERM),
    .W_IDX  (W_IDX)
  ) u_rr_selector (
    .i_req   (Req),
    .i_ptr   (r_ptr),
    .o_sel   (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_ptr_next  = (w_pick == W_IDX'(N_TERM - 1)) ? '0 : w_pick + 1'b1;
  assign w_monto_ext = W_BAL'(r_monto);
  // One extra bit so a deposit that would wrap the balance is detectable.
  assign w_suma      = {1'b0, r_balance} + {1'b0, w_monto_ext};

  always_comb begin
    w_res   = '0;
    w_nuevo = r_balance;
    if (r_tipo == DEPOSITO) begin
      if (!w_suma[W_BAL]) begin
        w_res.ok = 1'b1;
        w_nuevo  = w_suma[W_BAL-1:0];
      end
    end else if (w_monto_ext <= r_balance) begin
      w_res.ok = 1'b1;
      w_nuevo  = r_balance - w_monto_ext;
    end else begin
      w_res.fondos_insuf = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_tipo    <= DEPOSITO;
      r_monto   <= '0;
      r_balance <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_ok      <= 1'b0;
      r_fi      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An administrative load pre-empts arbitration for this cycle.
          if (Carga) begin
            r_balance <= Carga_valor;
          end else if (w_pick_valid) begin
            r_sel   <= w_pick;
            r_tipo  <= Tipo_trans[w_pick];
            r_monto <= Monto[w_pick*W_MONTO +: W_MONTO];
            r_ptr   <= w_ptr_next;
            r_gnt   <= N_TERM'(1'b1) << w_pick;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_gnt     <= '0;
          r_done    <= N_TERM'(1'b1) << r_sel;
          r_ok      <= w_res.ok;
          r_fi      <= w_res.fondos_insuf;
          r_balance <= w_nuevo;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          r_done  <= '0;
          r_ok    <= 1'b0;
          r_fi    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_ok    <= 1'b0;
          r_fi    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Gnt                  = r_gnt;
  assign Done                 = r_done;
  assign Ok                   = r_ok;
  assign Fondos_insuficientes = r_fi;
  assign Balance              = r_balance;
  assign Ocupado              = (r_state != ST_IDLE);
  assign o_estado             = r_state;

endmodule

// File: tb/tb_arbitro_balance.sv
// Bench for arbitro_balance: directed vector table, hand-written corner
// sequences and randomized multi-requester rounds against a transaction model.
`timescale 1ns/1ps
module tb_arbitro_balance;

  localparam int N  = 4;
  localparam int WM = 32;
  localparam int WB = 64;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              carga;
  logic [WB-1:0]     carga_valor;
  logic [N-1:0]      req;
  logic [N-1:0]      tipo;
  logic [N*WM-1:0]   monto;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic              ok;
  logic              fi;
  logic [WB-1:0]     bal;
  logic              ocupado;
  logic [1:0]        estado;

  arbitro_balance #(.N_TERM(N), .W_MONTO(WM), .W_BAL(WB)) dut (
    .CLK                  (clk),
    .Reset                (rst),
    .Carga                (carga),
    .Carga_valor          (carga_valor),
    .Req                  (req),
    .Tipo_trans           (tipo),
    .Monto                (monto),
    .Gnt                  (gnt),
    .Done                 (done),
    .Ok                   (ok),
    .Fondos_insuficientes (fi),
    .Balance              (bal),
    .Ocupado              (ocupado),
    .o_estado             (estado)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [WB-1:0] m_bal;
  int            m_ptr;
  logic [N-1:0]  exp_q[$];

  typedef struct {
    logic          do_load;
    logic [WB-1:0] load_val;
    int            term;
    logic          tipo;
    logic [WM-1:0] monto;
    logic          exp_ok;
    logic          exp_fi;
    logic [WB-1:0] exp_bal;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: plain 65-bit arithmetic on the balance.
  function automatic void model_txn(input logic [WB-1:0] b, input logic t, input logic [WM-1:0] m,
                                    output logic ok_o, output logic fi_o, output logic [WB-1:0] nb);
    logic [WB:0] total;
    logic [WB:0] limite;
    limite = {1'b0, {WB{1'b1}}};
    ok_o = 1'b0;
    fi_o = 1'b0;
    nb   = b;
    if (t == 1'b0) begin
      total = {1'b0, b} + {{(WB + 1 - WM){1'b0}}, m};
      if (total <= limite) begin
        ok_o = 1'b1;
        nb   = total[WB-1:0];
      end
    end else if ({{(WB - WM){1'b0}}, m} > b) begin
      fi_o = 1'b1;
    end else begin
      ok_o = 1'b1;
      nb   = b - {{(WB - WM){1'b0}}, m};
    end
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; carga = 1'b0; carga_valor = '0; req = '0; tipo = '0; monto = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_bal = '0;
    m_ptr = 0;
  endtask

  task automatic load(input logic [WB-1:0] v);
    carga = 1'b1;
    carga_valor = v;
    @(posedge clk);
    @(negedge clk);
    carga = 1'b0;
    chk("load_balance", bal, v);
    chk("load_idle", ocupado, 0);
    m_bal = v;
  endtask

  // Starts at a negedge in IDLE with requests driven; ends at a negedge in IDLE.
  task automatic serve_one(input int term, input logic e_ok, input logic e_fi,
                           input logic [WB-1:0] e_bal, input bit noise, input bit drop_early);
    logic [N-1:0] oh;
    oh = '0;
    oh[term] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("gnt_exec", gnt, oh);
    chk("ocupado_exec", ocupado, 1);
    chk("done_exec", done, 0);
    if (drop_early) req[term] = 1'b0;
    if (noise) begin
      carga = 1'b1;
      carga_valor = {$urandom, $urandom};
    end
    @(posedge clk);
    @(negedge clk);
    carga = 1'b0;
    chk("done_resp", done, oh);
    chk("ok_resp", ok, e_ok);
    chk("fondos_resp", fi, e_fi);
    chk("balance_resp", bal, e_bal);
    chk("gnt_resp", gnt, 0);
    req[term] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_idle", done, 0);
    chk("ok_idle", ok, 0);
    chk("ocupado_idle", ocupado, 0);
    m_ptr = (term + 1) % N;
    m_bal = e_bal;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic eo, ef;
    logic [WB-1:0] eb;
    logic [N-1:0] mask;
    int w;
    int t;
    vec_t v;

    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", ok, 0);
    chk("rst_fondos", fi, 0);
    chk("rst_balance", bal, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_estado", estado, 0);

    // directed vector table
    vecs.push_back(vec_t'{1'b1, 64'd1000, 0, 1'b0, 32'd250, 1'b1, 1'b0, 64'd1250});
    vecs.push_back(vec_t'{1'b1, 64'd100, 2, 1'b1, 32'd101, 1'b0, 1'b1, 64'd100});
    vecs.push_back(vec_t'{1'b0, 64'd0, 2, 1'b1, 32'd100, 1'b1, 1'b0, 64'd0});
    vecs.push_back(vec_t'{1'b0, 64'd0, 1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0});
    vecs.push_back(vec_t'{1'b0, 64'd0, 3, 1'b1, 32'd0, 1'b1, 1'b0, 64'd0});
    vecs.push_back(vec_t'{1'b0, 64'd0, 3, 1'b1, 32'd1, 1'b0, 1'b1, 64'd0});
    vecs.push_back(vec_t'{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 32'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back(vec_t'{1'b0, 64'd0, 1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0000});
    vecs.push_back(vec_t'{1'b1, 64'd5, 2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h1_0000_0004});
    vecs.push_back(vec_t'{1'b1, 64'd77, 0, 1'b0, 32'd23, 1'b1, 1'b0, 64'd100});
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.do_load) load(v.load_val);
      tipo[v.term] = v.tipo;
      monto[v.term*WM +: WM] = v.monto;
      req[v.term] = 1'b1;
      serve_one(v.term, v.exp_ok, v.exp_fi, v.exp_bal, 1'b0, 1'b0);
    end

    // all four terminals requesting at once, pointer starting at 0
    do_reset();
    load(64'd10);
    tipo = '0;
    for (int i = 0; i < N; i++) monto[i*WM +: WM] = 32'd1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    req = 4'b1111;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt != '0) begin
        if (exp_q.size() == 0) chk("rr_extra_grant", gnt, 0);
        else chk("rr_order", gnt, exp_q.pop_front());
      end
      chk("rr_ocupado", ocupado, (cyc % 3) != 2);
      if (done != '0) req = req & ~done;
    end
    chk("rr_all_served", exp_q.size(), 0);
    chk("rr_balance", bal, 64'd14);
    m_bal = 64'd14;
    m_ptr = 0;

    // reset during EXEC aborts the withdrawal
    load(64'd500);
    tipo[1] = 1'b1;
    monto[1*WM +: WM] = 32'd50;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt_exec", gnt, 4'b0010);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_balance", bal, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_estado", estado, 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_late_done", done, 0);
    m_bal = '0;
    m_ptr = 0;

    // load and request in the same IDLE cycle: load first, then grant
    carga = 1'b1;
    carga_valor = 64'd777;
    tipo[3] = 1'b0;
    monto[3*WM +: WM] = 32'd23;
    req[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    carga = 1'b0;
    chk("carga_prio_gnt", gnt, 0);
    chk("carga_prio_balance", bal, 64'd777);
    chk("carga_prio_ocupado", ocupado, 0);
    serve_one(3, 1'b1, 1'b0, 64'd800, 1'b0, 1'b0);

    // randomized rounds of simultaneous requests
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) load({32'h0, $urandom});
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        tipo[k] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: monto[k*WM +: WM] = '0;
          1: monto[k*WM +: WM] = $urandom;
          2: monto[k*WM +: WM] = m_bal[WM-1:0] + WM'($urandom_range(0, 2)) - WM'(1);
          default: monto[k*WM +: WM] = WM'($urandom_range(0, 1000));
        endcase
      end
      req = mask;
      while (req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          t = (m_ptr + k) % N;
          if (w < 0 && req[t]) w = t;
        end
        model_txn(m_bal, tipo[w], monto[w*WM +: WM], eo, ef, eb);
        serve_one(w, eo, ef, eb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
